ten_meter_pulse_gen: RTL

Front end of the distance path. It converts the raw wheel-sensor (Hall) signal into the one-strobe-per-10-m `ten_meter_pulse` consumed by `distance_fare`. The input is synchronised, debounced, and divided by a run-time wheel-pulses-per-10-m ratio. The block also reports whether the vehicle is moving, which drives waiting-time charging. It sits between the board sensor pin and `distance_fare`, in the same clock domain as the rest of the meter.

---
 rtl/taxi_meter_pkg.sv | 16 +
 rtl/wheel_debounce.sv | 76 +++++++
 rtl/ten_meter_pulse_gen.sv | 72 +++++++
 3 files changed

// File: rtl/taxi_meter_pkg.sv
// Shared defaults and encodings for the taxi meter datapath.
// The debounce defaults target a 50 MHz clock: 20 us of stability and a 1 s stop window.
package taxi_meter_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEBOUNCE_CYC    = CLK_HZ / 50_000;
  localparam int STOP_WINDOW_CYC = CLK_HZ;

  typedef enum logic [1:0] {
    LO     = 2'd0,
    CHK_HI = 2'd1,
    HI     = 2'd2,
    CHK_LO = 2'd3
  } deb_state_t;

endpackage

// File: rtl/wheel_debounce.sv
// Two-flop synchroniser plus four-state debouncer for a bouncy switch or Hall input.
// evt pulses for one cycle when a rising level has been stable for DEBOUNCE_CYC cycles.
module wheel_debounce #(
  parameter int DEBOUNCE_CYC = taxi_meter_pkg::DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic evt
);
  import taxi_meter_pkg::*;

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_reg;
  logic          w_s;
  deb_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  assign w_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b00;
      state_reg <= LO;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], din};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // evt is decoded combinationally so the registered downstream strobe lands one cycle later.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    evt        = 1'b0;
    case (state_reg)
      LO: begin
        if (w_s) begin
          state_next = CHK_HI;
          cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!w_s) begin
          state_next = LO;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = HI;
          evt        = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HI: begin
        if (!w_s) begin
          state_next = CHK_LO;
          cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (w_s) begin
          state_next = HI;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = LO;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = LO;
    endcase
  end

endmodule

// File: rtl/ten_meter_pulse_gen.sv
// Converts debounced wheel edges into one strobe per 10 m and reports motion.
// The divider runs only while en is high; the motion timer runs regardless.
module ten_meter_pulse_gen #(
  parameter int CLK_HZ          = taxi_meter_pkg::CLK_HZ,
  parameter int DEBOUNCE_CYC    = CLK_HZ / 50_000,
  parameter int STOP_WINDOW_CYC = CLK_HZ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wheel_in,
  input  logic [7:0] pulses_per_ten_m,
  output logic       ten_meter_pulse,
  output logic       moving
);

  localparam int SW = $clog2(STOP_WINDOW_CYC + 1);
  localparam logic [SW-1:0] STOP_MAX = SW'(STOP_WINDOW_CYC);

  logic          wheel_evt;
  logic [7:0]    pcnt;
  logic [7:0]    ratio;
  logic          wrap;
  logic [SW-1:0] stimer, stimer_next;

  wheel_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (wheel_in),
    .evt  (wheel_evt)
  );

  assign ratio = (pulses_per_ten_m == 8'd0) ? 8'd1 : pulses_per_ten_m;
  // Widened compare so a ratio lowered below pcnt still wraps on the next event.
  assign wrap  = ({1'b0, pcnt} + 9'd1) >= {1'b0, ratio};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt            <= 8'd0;
      ten_meter_pulse <= 1'b0;
    end else begin
      ten_meter_pulse <= en & wheel_evt & wrap;
      if (!en) begin
        pcnt <= 8'd0;
      end else if (wheel_evt) begin
        pcnt <= wrap ? 8'd0 : pcnt + 8'd1;
      end
    end
  end

  always_comb begin
    stimer_next = stimer;
    if (wheel_evt) begin
      stimer_next = '0;
    end else if (stimer != STOP_MAX) begin
      stimer_next = stimer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stimer <= STOP_MAX;
      moving <= 1'b0;
    end else begin
      stimer <= stimer_next;
      moving <= (stimer_next < STOP_MAX);
    end
  end

endmodule
